// File: rtl/nbit_arith_pkg.sv
//------------------------------------------------------------------------------
// nbit_arith_pkg
// Shared types for the serial add/subtract block: the operation select
// encoding and the control FSM state encoding.
//------------------------------------------------------------------------------
package nbit_arith_pkg;

    // opcode[1] selects the X source (0: a_in, 1: accumulator),
    // opcode[0] selects subtract (Y inverted, carry-in of 1).
    typedef enum logic [1:0] {
        OP_ADD     = 2'b00,
        OP_SUB     = 2'b01,
        OP_ACC_ADD = 2'b10,
        OP_ACC_SUB = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/nbit_add_sub_slice.sv
//------------------------------------------------------------------------------
// nbit_add_sub_slice
// One CHUNK-bit ripple add with carry-in and carry-out. The serial top reuses
// a single instance for every slice of the operands.
//
// Ports:
//   i_a, i_b  CHUNK-bit addends
//   i_cin     carry into bit 0
//   o_sum     CHUNK-bit sum
//   o_cout    carry out of the slice MSB
//------------------------------------------------------------------------------
module nbit_add_sub_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_sum,
    output logic             o_cout
);

    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_cin};

endmodule

// File: rtl/nbit_add_sub_serial.sv
//------------------------------------------------------------------------------
// nbit_add_sub_serial
// Serial N-bit adder/subtractor with accumulator. An accepted operation is
// processed CHUNK bits per cycle, LSB slice first, through one shared slice
// adder; the result is presented with a valid/ready handshake.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   a_in, b_in            N-bit operands
//   opcode                00 a+b, 01 a-b, 10 acc+b, 11 acc-b
//   in_valid / in_ready   operation handshake (ready only in IDLE)
//   acc_clr_in            synchronous accumulator clear (wins over writeback)
//   sum_or_diff_out       N-bit result
//   carry_or_borrow_out   final carry (for subtract: 1 = no borrow)
//   overflow_out          two's-complement signed overflow
//   out_valid / out_ready result handshake (valid only in DONE)
//
// Build option: define NBIT_ADD_SUB_SAT_EN to clamp an overflowing result to
// signed max/min (sign taken from X); otherwise the result wraps modulo 2^N.
//------------------------------------------------------------------------------
module nbit_add_sub_serial
    import nbit_arith_pkg::*;
#(
    parameter int N     = 8,
    parameter int CHUNK = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] a_in,
    input  logic [N-1:0] b_in,
    input  logic [1:0]   opcode,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         acc_clr_in,
    output logic [N-1:0] sum_or_diff_out,
    output logic         carry_or_borrow_out,
    output logic         overflow_out,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int NSLICE = N / CHUNK;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if ((N % CHUNK) != 0) begin : g_bad_chunk
        $error("nbit_add_sub_serial: N (%0d) must be a multiple of CHUNK (%0d)", N, CHUNK);
    end

    state_e          r_state;
    logic [N-1:0]    r_x;
    logic [N-1:0]    r_y;
    logic [N-1:0]    r_res;
    logic [N-1:0]    r_acc;
    logic            r_carry;
    logic            r_ovf;
    logic            r_is_acc;
    logic [CW-1:0]   r_cnt;

    int              w_lsb;
    logic [CHUNK-1:0] w_sum;
    logic            w_cout;
    logic [N-1:0]    w_res_full;
    logic [N-1:0]    w_res_final;
    logic            w_ovf;
    logic            w_last;

    assign w_last = (r_cnt == CW'(NSLICE - 1));

    nbit_add_sub_slice #(.CHUNK(CHUNK)) u_slice (
        .i_a    (r_x[w_lsb +: CHUNK]),
        .i_b    (r_y[w_lsb +: CHUNK]),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // Result with the current slice merged in; on the last slice this is the
    // complete N-bit result, from which overflow and saturation are derived.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path first,
        // otherwise synthesis infers a latch to hold the old value.
        w_lsb       = CHUNK * int'(r_cnt);
        w_res_full  = r_res;
        w_res_full[w_lsb +: CHUNK] = w_sum;
        w_ovf       = (r_x[N-1] == r_y[N-1]) && (w_res_full[N-1] != r_x[N-1]);
`ifdef NBIT_ADD_SUB_SAT_EN
        if (w_ovf) begin
            w_res_final = r_x[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end else begin
            w_res_final = w_res_full;
        end
`else
        w_res_final = w_res_full;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state uses non-blocking assignments so every register samples
        // pre-edge values regardless of statement order.
        if (!rst_n) begin
            r_state  <= IDLE;
            r_x      <= '0;
            r_y      <= '0;
            r_res    <= '0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_is_acc <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_x      <= opcode[1] ? r_acc : a_in;
                        r_y      <= opcode[0] ? ~b_in : b_in;
                        r_carry  <= opcode[0];
                        r_is_acc <= opcode[1];
                        r_cnt    <= '0;
                        r_state  <= CALC;
                    end
                end
                CALC: begin
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_res   <= w_res_final;
                        r_ovf   <= w_ovf;
                        r_state <= DONE;
                    end else begin
                        r_res   <= w_res_full;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Accumulator: clear has priority over the writeback on DONE entry.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the accumulator is architectural state and is reset; a plain
        // data array with no defined reset value would be left unreset.
        if (!rst_n) begin
            r_acc <= '0;
        end else if (acc_clr_in) begin
            r_acc <= '0;
        end else if ((r_state == CALC) && w_last && r_is_acc) begin
            r_acc <= w_res_final;
        end
    end

    assign in_ready            = (r_state == IDLE);
    assign out_valid           = (r_state == DONE);
    assign sum_or_diff_out     = r_res;
    assign carry_or_borrow_out = r_carry;
    assign overflow_out        = r_ovf;

endmodule

// File: tb/tb_nbit_add_sub_serial.sv
//------------------------------------------------------------------------------
// tb_nbit_add_sub_serial
// Self-checking bench for nbit_add_sub_serial (N=8, CHUNK=4): directed vector
// table, randomized operations against an arithmetic reference model, and
// hand-written sequences for backpressure, clear priority and mid-op reset.
//------------------------------------------------------------------------------
module tb_nbit_add_sub_serial;
    import nbit_arith_pkg::*;

    localparam int N     = 8;
    localparam int CHUNK = 4;
    localparam int LAT   = N / CHUNK;

`ifdef NBIT_ADD_SUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] a_in = '0;
    logic [N-1:0] b_in = '0;
    logic [1:0]   opcode = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         acc_clr_in = 1'b0;
    logic [N-1:0] sum_or_diff_out;
    logic         carry_or_borrow_out;
    logic         overflow_out;
    logic         out_valid;
    logic         out_ready = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [7:0] m_acc = 8'h00;

    always #5 clk = ~clk;

    nbit_add_sub_serial #(.N(N), .CHUNK(CHUNK)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .a_in                (a_in),
        .b_in                (b_in),
        .opcode              (opcode),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .acc_clr_in          (acc_clr_in),
        .sum_or_diff_out     (sum_or_diff_out),
        .carry_or_borrow_out (carry_or_borrow_out),
        .overflow_out        (overflow_out),
        .out_valid           (out_valid),
        .out_ready           (out_ready)
    );

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       clr_before;
        logic [7:0] exp_res;
        logic       exp_c;
        logic       exp_v;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands as unsigned and signed.
    function automatic void model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                                  input logic [7:0] acc, output logic [7:0] res,
                                  output logic c, output logic v);
        int x, sx, sb, sr;
        x  = op[1] ? int'(acc) : int'(a);
        sx = (x >= 128) ? x - 256 : x;
        sb = (int'(b) >= 128) ? int'(b) - 256 : int'(b);
        if (op[0]) begin
            sr = sx - sb;
            c  = (x >= int'(b));
        end else begin
            sr = sx + sb;
            c  = (x + int'(b)) > 255;
        end
        v   = (sr > 127) || (sr < -128);
        res = 8'(sr);
        if (SAT && v) res = (sr > 127) ? 8'h7F : 8'h80;
    endfunction

    task automatic pulse_clr();
        acc_clr_in = 1'b1;
        @(negedge clk);
        acc_clr_in = 1'b0;
    endtask

    // Present one operation; returns at the falling edge after the accept edge.
    task automatic start_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("start_timeout", 32'(in_ready), 32'd1);
        opcode   = op;
        a_in     = a;
        b_in     = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Counts rising edges after the accept edge until out_valid is seen.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) check("done_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] res, output logic c, output logic v, output int lat);
        start_op(op, a, b);
        wait_done(lat);
        res = sum_or_diff_out;
        c   = carry_or_borrow_out;
        v   = overflow_out;
        finish_op();
    endtask

    initial begin
        logic [7:0] r, er, hold_r;
        logic       c, v, ec, ev, hold_c, hold_v;
        logic [1:0] op;
        logic [7:0] a, b;
        int         lat;

        vecs[0]  = '{OP_ADD,     8'h7F, 8'h01, 1'b0, SAT ? 8'h7F : 8'h80, 1'b0, 1'b1};
        vecs[1]  = '{OP_SUB,     8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0};
        vecs[2]  = '{OP_SUB,     8'h07, 8'h05, 1'b0, 8'h02, 1'b1, 1'b0};
        vecs[3]  = '{OP_ADD,     8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[4]  = '{OP_SUB,     8'h80, 8'h01, 1'b0, SAT ? 8'h80 : 8'h7F, 1'b1, 1'b1};
        vecs[5]  = '{OP_ADD,     8'h80, 8'h80, 1'b0, SAT ? 8'h80 : 8'h00, 1'b1, 1'b1};
        vecs[6]  = '{OP_SUB,     8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[7]  = '{OP_ACC_ADD, 8'hAA, 8'h0A, 1'b1, 8'h0A, 1'b0, 1'b0};
        vecs[8]  = '{OP_ACC_ADD, 8'h55, 8'h0A, 1'b0, 8'h14, 1'b0, 1'b0};
        vecs[9]  = '{OP_ACC_ADD, 8'h00, 8'h0A, 1'b0, 8'h1E, 1'b0, 1'b0};
        vecs[10] = '{OP_ACC_SUB, 8'hFF, 8'h05, 1'b0, 8'h19, 1'b1, 1'b0};

        // Reset state while rst_n is held low
        #12;
        check("rst_in_ready",  32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum",       32'(sum_or_diff_out), 32'd0);
        check("rst_carry",     32'(carry_or_borrow_out), 32'd0);
        check("rst_ovf",       32'(overflow_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vector table
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].clr_before) begin
                pulse_clr();
                m_acc = 8'h00;
            end
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, c, v, lat);
            check($sformatf("vec%0d_res", i), 32'(r), 32'(vecs[i].exp_res));
            check($sformatf("vec%0d_carry", i), 32'(c), 32'(vecs[i].exp_c));
            check($sformatf("vec%0d_ovf", i), 32'(v), 32'(vecs[i].exp_v));
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(LAT));
            model(vecs[i].op, vecs[i].a, vecs[i].b, m_acc, er, ec, ev);
            if (vecs[i].op[1]) m_acc = er;
        end

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = 8'($urandom);
            b  = 8'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                pulse_clr();
                m_acc = 8'h00;
            end
            model(op, a, b, m_acc, er, ec, ev);
            run_op(op, a, b, r, c, v, lat);
            check($sformatf("rnd%0d_res", i), 32'(r), 32'(er));
            check($sformatf("rnd%0d_carry", i), 32'(c), 32'(ec));
            check($sformatf("rnd%0d_ovf", i), 32'(v), 32'(ev));
            check($sformatf("rnd%0d_lat", i), 32'(lat), 32'(LAT));
            if (op[1]) m_acc = er;
        end

        // Backpressure: result held in DONE, new requests ignored
        start_op(OP_ADD, 8'h12, 8'h34);
        wait_done(lat);
        hold_r = sum_or_diff_out;
        hold_c = carry_or_borrow_out;
        hold_v = overflow_out;
        check("bp_res", 32'(hold_r), 32'h46);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            opcode   = OP_SUB;
            a_in     = 8'($urandom);
            b_in     = 8'($urandom);
            @(negedge clk);
            check($sformatf("bp%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d_ready", i), 32'(in_ready), 32'd0);
            check($sformatf("bp%0d_res", i), 32'(sum_or_diff_out), 32'(hold_r));
            check($sformatf("bp%0d_carry", i), 32'(carry_or_borrow_out), 32'(hold_c));
            check($sformatf("bp%0d_ovf", i), 32'(overflow_out), 32'(hold_v));
        end
        in_valid = 1'b0;
        finish_op();
        check("bp_idle_ready", 32'(in_ready), 32'd1);
        check("bp_idle_valid", 32'(out_valid), 32'd0);
        run_op(OP_ADD, 8'h01, 8'h01, r, c, v, lat);
        check("bp_next_res", 32'(r), 32'h02);

        // Clear coincides with the accumulate writeback on DONE entry
        pulse_clr();
        m_acc = 8'h00;
        run_op(OP_ACC_ADD, 8'h00, 8'h21, r, c, v, lat);
        check("clr_pre_res", 32'(r), 32'h21);
        m_acc = 8'h21;
        model(OP_ACC_ADD, 8'h00, 8'h33, m_acc, er, ec, ev);
        start_op(OP_ACC_ADD, 8'h00, 8'h33);
        @(negedge clk);
        acc_clr_in = 1'b1;
        @(negedge clk);
        acc_clr_in = 1'b0;
        check("clr_done_valid", 32'(out_valid), 32'd1);
        check("clr_done_res", 32'(sum_or_diff_out), 32'(er));
        finish_op();
        m_acc = 8'h00;
        run_op(OP_ACC_ADD, 8'hFF, 8'h01, r, c, v, lat);
        check("clr_after_res", 32'(r), 32'h01);

        // Reset asserted mid-CALC after slice 0
        pulse_clr();
        start_op(OP_ACC_ADD, 8'h00, 8'h44);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mrst_in_ready",  32'(in_ready), 32'd1);
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_sum",       32'(sum_or_diff_out), 32'd0);
        check("mrst_carry",     32'(carry_or_borrow_out), 32'd0);
        check("mrst_ovf",       32'(overflow_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_acc = 8'h00;
        @(negedge clk);
        run_op(OP_ACC_ADD, 8'hEE, 8'h03, r, c, v, lat);
        check("mrst_next_res", 32'(r), 32'h03);
        check("mrst_next_carry", 32'(c), 32'd0);
        check("mrst_next_lat", 32'(lat), 32'(LAT));
        run_op(OP_SUB, 8'h20, 8'h30, r, c, v, lat);
        check("mrst_sub_res", 32'(r), 32'hF0);
        check("mrst_sub_carry", 32'(c), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
